// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP; the result is held until its owner consumes it.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_overflow,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_inputa,
  output logic [WIDTH-1:0] alu_inputb,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             owner;
  logic [1:0]       gnt;
  logic             accept0;
  logic             accept1;
  logic             rsp_take;

  logic [1:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] out_p1;
  logic             ovf_p1;

  // A lone requester always wins; on a tie the port that was not served last wins.
  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic last_g);
    logic [1:0] g;
    g[0] = v0 && (!v1 || last_g);
    g[1] = v1 && (!v0 || !last_g);
    return g;
  endfunction

  always_comb begin
    gnt        = rr_grant(req0_valid, req1_valid, last);
    req0_ready = rst_n && (state == IDLE) && gnt[0];
    req1_ready = rst_n && (state == IDLE) && gnt[1];
    accept0    = req0_valid && req0_ready;
    accept1    = req1_valid && req1_ready;
    rsp0_valid = rst_n && (state == RESP) && !owner;
    rsp1_valid = rst_n && (state == RESP) && owner;
    rsp_take   = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    busy       = rst_n && (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept0 || accept1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture on acceptance; stage p1: ALU result capture in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      op_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      out_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept0 || accept1) begin
        owner <= accept1;
        op_p0 <= accept1 ? req1_op : req0_op;
        a_p0  <= accept1 ? req1_a  : req0_a;
        b_p0  <= accept1 ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        out_p1 <= alu_out;
        ovf_p1 <= alu_overflow;
      end
      if (rsp_take) last <= owner;
    end
  end

  assign alu_op       = op_p0;
  assign alu_inputa   = a_p0;
  assign alu_inputb   = b_p0;
  assign rsp_out      = out_p1;
  assign rsp_overflow = ovf_p1;

endmodule
